// File: rtl/ibuf_pkg.sv
// Shared types and default sizing for the SPU front-end instruction buffer.
// Optional even/odd issue pairing is enabled by defining IBUF_PAIR_ALIGN_EN.
package ibuf_pkg;

  localparam int unsigned IbufDepth     = 16;
  localparam int unsigned IbufLineWords = 4;
  localparam int unsigned IbufPcW       = 8;

  typedef logic [IbufPcW-1:0] pc_t;

  typedef struct packed {
    logic [31:0] instr;
    pc_t         pc;
  } ibuf_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } ibuf_state_t;

  // Word-PC increment; wraps modulo 2^IbufPcW.
  function automatic pc_t pc_add(pc_t base, int unsigned k);
    return base + pc_t'(k);
  endfunction

endpackage

// File: rtl/ibuf_ptr_ctl.sv
// Pointer, occupancy and FSM control for the instruction buffer: decides when
// a fetched line is accepted and how many head entries decode consumes.
module ibuf_ptr_ctl
  import ibuf_pkg::*;
#(
  parameter int unsigned  Depth     = IbufDepth,
  parameter int unsigned  LineWords = IbufLineWords,
  localparam int unsigned PtrW      = $clog2(Depth),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            line_valid_i,
  input  logic            flush_i,
  input  logic            issue_stall_i,
  input  logic            slot0_valid_i,
  input  logic            slot1_valid_i,
  output logic            line_ready_o,
  output logic            push_o,
  output logic [PtrW-1:0] wr_ptr_o,
  output logic [PtrW-1:0] rd_ptr_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] LineCnt  = CntW'(LineWords);
  localparam logic [PtrW-1:0] LinePtr  = PtrW'(LineWords);

  ibuf_state_t     state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] free_cnt;
  logic [CntW-1:0] push_cnt;
  logic [CntW-1:0] pop_cnt;
  logic            pop_en;

  assign free_cnt = DepthCnt - count_q;

  // Held low while reset is asserted so fetch never sees a spurious ready.
  assign line_ready_o = rst_ni && (state_q != StFlush) && (free_cnt >= LineCnt);
  assign push_o       = line_valid_i && line_ready_o && !flush_i;
  assign pop_en       = !issue_stall_i && !flush_i;

  assign push_cnt = push_o ? LineCnt : '0;
  assign pop_cnt  = pop_en ? (CntW'(slot0_valid_i) + CntW'(slot1_valid_i)) : '0;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      state_d  = StFlush;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + (push_o ? LinePtr : '0);
      rd_ptr_d = rd_ptr_q + pop_cnt[PtrW-1:0];
      count_d  = count_q + push_cnt - pop_cnt;
      case (state_q)
        StIdle:  if (push_o) state_d = StRun;
        StRun:   if (count_d == '0) state_d = StIdle;
        StFlush: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and dual-issue decode: line-wide writes,
// up to two head instructions presented per cycle. Define IBUF_PAIR_ALIGN_EN
// to only pair an even-PC head with its odd successor.
module instr_buffer
  import ibuf_pkg::*;
#(
  parameter int unsigned  Depth     = IbufDepth,
  parameter int unsigned  LineWords = IbufLineWords,
  localparam int unsigned PtrW      = $clog2(Depth),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       line_valid_i,
  input  logic [LineWords-1:0][31:0] line_instr_i,
  input  logic [IbufPcW-1:0]         line_pc_i,
  output logic                       line_ready_o,
  input  logic                       flush_i,
  input  logic                       issue_stall_i,
  output logic                       out_valid0_o,
  output logic                       out_valid1_o,
  output logic [31:0]                out_instr0_o,
  output logic [31:0]                out_instr1_o,
  output logic [IbufPcW-1:0]         out_pc0_o,
  output logic [IbufPcW-1:0]         out_pc1_o,
  output logic [CntW-1:0]            occupancy_o
);

  ibuf_entry_t     mem_q [Depth];
  ibuf_entry_t     head0, head1;
  logic            push;
  logic [PtrW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CntW-1:0] count;
  logic            avail0, avail1, pair_ok;

  ibuf_ptr_ctl #(
    .Depth     (Depth),
    .LineWords (LineWords)
  ) u_ptr_ctl (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .line_valid_i  (line_valid_i),
    .flush_i       (flush_i),
    .issue_stall_i (issue_stall_i),
    .slot0_valid_i (out_valid0_o),
    .slot1_valid_i (out_valid1_o),
    .line_ready_o  (line_ready_o),
    .push_o        (push),
    .wr_ptr_o      (wr_ptr),
    .rd_ptr_o      (rd_ptr),
    .count_o       (count)
  );

  // Storage is intentionally not reset; count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int unsigned k = 0; k < LineWords; k++) begin
        mem_q[wr_ptr + PtrW'(k)] <= '{instr: line_instr_i[k], pc: pc_add(line_pc_i, k)};
      end
    end
  end

  assign rd_ptr_nxt = rd_ptr + PtrW'(1);
  assign head0      = mem_q[rd_ptr];
  assign head1      = mem_q[rd_ptr_nxt];

  assign avail0 = (count != '0);
  assign avail1 = (count > CntW'(1));

`ifdef IBUF_PAIR_ALIGN_EN
  assign pair_ok = !head0.pc[0] && (head1.pc == pc_add(head0.pc, 1));
`else
  assign pair_ok = 1'b1;
`endif

  assign out_valid0_o = avail0;
  assign out_valid1_o = avail1 && pair_ok;

  always_comb begin
    out_instr0_o = '0;
    out_pc0_o    = '0;
    out_instr1_o = '0;
    out_pc1_o    = '0;
    if (out_valid0_o) begin
      out_instr0_o = head0.instr;
      out_pc0_o    = head0.pc;
    end
    if (out_valid1_o) begin
      out_instr1_o = head1.instr;
      out_pc1_o    = head1.pc;
    end
  end

  assign occupancy_o = count;

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: queue-based reference model compared
// every cycle, plus literal expectations at the directed scenario points.
module tb_instr_buffer;

  localparam int unsigned Depth = 16;
  localparam int unsigned LW    = 4;
  localparam int unsigned CntW  = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                line_valid = 1'b0;
  logic [LW-1:0][31:0] line_instr = '0;
  logic [7:0]          line_pc = '0;
  logic                flush = 1'b0;
  logic                stall = 1'b0;
  logic                line_ready, v0, v1;
  logic [31:0]         i0, i1;
  logic [7:0]          p0, p1;
  logic [CntW-1:0]     occ;

  always #5 clk = ~clk;

  instr_buffer #(
    .Depth     (Depth),
    .LineWords (LW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .line_valid_i  (line_valid),
    .line_instr_i  (line_instr),
    .line_pc_i     (line_pc),
    .line_ready_o  (line_ready),
    .flush_i       (flush),
    .issue_stall_i (stall),
    .out_valid0_o  (v0),
    .out_valid1_o  (v1),
    .out_instr0_o  (i0),
    .out_instr1_o  (i1),
    .out_pc0_o     (p0),
    .out_pc1_o     (p1),
    .occupancy_o   (occ)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of issued-order instructions.
  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } ment_t;

  ment_t mq[$];
  logic  m_fl = 1'b0;

  initial begin : cmp
    logic                ev0, ev1, erdy;
    logic                c_valid, c_flush, c_stall;
    logic [LW-1:0][31:0] c_instr;
    logic [7:0]          c_pc;
    logic [31:0]         ei0, ei1;
    logic [7:0]          ep0, ep1;
    int                  n;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_fl = 1'b0;
      end
      n   = mq.size();
      ev0 = rst_n && !m_fl && (n >= 1);
      ev1 = rst_n && !m_fl && (n >= 2);
`ifdef IBUF_PAIR_ALIGN_EN
      if (ev1) ev1 = (mq[0].pc[0] == 1'b0) && (mq[1].pc == 8'(mq[0].pc + 8'd1));
`endif
      erdy = rst_n && !m_fl && ((int'(Depth) - n) >= int'(LW));
      ei0  = ev0 ? mq[0].instr : 32'd0;
      ep0  = ev0 ? mq[0].pc : 8'd0;
      ei1  = ev1 ? mq[1].instr : 32'd0;
      ep1  = ev1 ? mq[1].pc : 8'd0;
      chk("out_valid0", 32'(v0), 32'(ev0));
      chk("out_valid1", 32'(v1), 32'(ev1));
      chk("out_instr0", i0, ei0);
      chk("out_instr1", i1, ei1);
      chk("out_pc0", 32'(p0), 32'(ep0));
      chk("out_pc1", 32'(p1), 32'(ep1));
      chk("line_ready", 32'(line_ready), 32'(erdy));
      chk("occupancy", 32'(occ), 32'(n));
      c_valid = line_valid;
      c_flush = flush;
      c_stall = stall;
      c_instr = line_instr;
      c_pc    = line_pc;
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        m_fl = 1'b0;
      end else if (c_flush) begin
        mq.delete();
        m_fl = 1'b1;
      end else begin
        m_fl = 1'b0;
        if (!c_stall) begin
          if (ev0) void'(mq.pop_front());
          if (ev1) void'(mq.pop_front());
        end
        if (c_valid && erdy) begin
          for (int k = 0; k < int'(LW); k++) begin
            mq.push_back('{instr: c_instr[k], pc: 8'(c_pc + 8'(k))});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input logic [7:0] pc, input logic [31:0] base);
    line_valid = 1'b1;
    line_pc    = pc;
    for (int k = 0; k < int'(LW); k++) line_instr[k] = base + 32'(k);
  endtask

  initial begin : stim
    // Reset
    #2;
    chk("rst_ready", 32'(line_ready), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(line_ready), 32'd1);

    // Basic line at 0x10, no stall
    step(); drive_line(8'h10, 32'hA0A0_0000);
    step(); line_valid = 1'b0;
    @(negedge clk);
    chk("t1_i0", i0, 32'hA0A0_0000);
    chk("t1_p0", 32'(p0), 32'h10);
    chk("t1_i1", i1, 32'hA0A0_0001);
    chk("t1_p1", 32'(p1), 32'h11);
    chk("t1_occ", 32'(occ), 32'd4);
    step(); @(negedge clk);
    chk("t1_p0b", 32'(p0), 32'h12);
    chk("t1_p1b", 32'(p1), 32'h13);
    chk("t1_i1b", i1, 32'hA0A0_0003);
    step(); @(negedge clk);
    chk("t1_empty_occ", 32'(occ), 32'd0);
    chk("t1_empty_v0", 32'(v0), 32'd0);

    // Fill to full under stall; a fifth line is ignored
    step(); stall = 1'b1; drive_line(8'h40, 32'h4000_0000);
    for (int i = 1; i < 4; i++) begin
      step(); drive_line(8'(8'h40 + 8'(4 * i)), 32'h4000_0000 + 32'(32'h100 * i));
    end
    step(); drive_line(8'h80, 32'h8000_0000);
    @(negedge clk);
    chk("t2_full_occ", 32'(occ), 32'd16);
    chk("t2_full_ready", 32'(line_ready), 32'd0);
    step(); @(negedge clk);
    chk("t2_ignored_occ", 32'(occ), 32'd16);
    step(); line_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("t2_occ16", 32'(occ), 32'd16);
    step(); @(negedge clk);
    chk("t2_occ14", 32'(occ), 32'd14);
    chk("t2_ready14", 32'(line_ready), 32'd0);
    chk("t2_p0_14", 32'(p0), 32'h42);
    step(); @(negedge clk);
    chk("t2_occ12", 32'(occ), 32'd12);
    chk("t2_ready12", 32'(line_ready), 32'd1);
    chk("t2_p0_12", 32'(p0), 32'h44);
    repeat (6) step();
    @(negedge clk);
    chk("t2_drained", 32'(occ), 32'd0);

    // PC wrap
    step(); drive_line(8'hFE, 32'hC000_0000);
    step(); line_valid = 1'b0;
    @(negedge clk);
    chk("t3_p0", 32'(p0), 32'hFE);
    chk("t3_p1", 32'(p1), 32'hFF);
    step(); @(negedge clk);
    chk("t3_p0b", 32'(p0), 32'h00);
    chk("t3_p1b", 32'(p1), 32'h01);
    chk("t3_i1b", i1, 32'hC000_0003);
    step();

    // Flush with a simultaneous line at occupancy 6
    step(); stall = 1'b1; drive_line(8'h60, 32'h6000_0000);
    step(); drive_line(8'h64, 32'h6400_0000);
    step(); line_valid = 1'b0; stall = 1'b0;
    step(); stall = 1'b1;
    @(negedge clk);
    chk("t4_occ6", 32'(occ), 32'd6);
    chk("t4_p0", 32'(p0), 32'h62);
    step(); flush = 1'b1; drive_line(8'h70, 32'h7000_0000);
    step(); flush = 1'b0; line_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("t4_fl_v0", 32'(v0), 32'd0);
    chk("t4_fl_v1", 32'(v1), 32'd0);
    chk("t4_fl_ready", 32'(line_ready), 32'd0);
    chk("t4_fl_occ", 32'(occ), 32'd0);
    step(); @(negedge clk);
    chk("t4_idle_ready", 32'(line_ready), 32'd1);
    chk("t4_idle_v0", 32'(v0), 32'd0);

    // Asynchronous reset mid-operation
    step(); stall = 1'b1; drive_line(8'h90, 32'h9000_0000);
    step(); drive_line(8'h94, 32'h9400_0000);
    step(); drive_line(8'h98, 32'h9800_0000);
    step(); line_valid = 1'b0; stall = 1'b0;
    step(); stall = 1'b1;
    @(negedge clk);
    chk("t5_occ10", 32'(occ), 32'd10);
    step(); #2 rst_n = 1'b0;
    #1;
    chk("t5_async_occ", 32'(occ), 32'd0);
    chk("t5_async_v0", 32'(v0), 32'd0);
    chk("t5_async_ready", 32'(line_ready), 32'd0);
    chk("t5_async_i0", i0, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; stall = 1'b0;
    @(negedge clk);
    chk("t5_rel_ready", 32'(line_ready), 32'd1);
    chk("t5_rel_occ", 32'(occ), 32'd0);

    // Odd-PC head
    step(); drive_line(8'h21, 32'h2100_0000);
    step(); line_valid = 1'b0;
    @(negedge clk);
    chk("t6_p0", 32'(p0), 32'h21);
`ifdef IBUF_PAIR_ALIGN_EN
    chk("t6_v1_alone", 32'(v1), 32'd0);
    step(); @(negedge clk);
    chk("t6_p0b", 32'(p0), 32'h22);
    chk("t6_v1b", 32'(v1), 32'd1);
    chk("t6_p1b", 32'(p1), 32'h23);
`else
    chk("t6_v1", 32'(v1), 32'd1);
    chk("t6_p1", 32'(p1), 32'h22);
    step(); @(negedge clk);
    chk("t6_p0b", 32'(p0), 32'h23);
    chk("t6_p1b", 32'(p1), 32'h24);
`endif
    repeat (3) step();
    @(negedge clk);
    chk("t6_drained", 32'(occ), 32'd0);

    // Mixed traffic: stalls, odd line PCs, one flush
    for (int i = 0; i < 40; i++) begin
      step();
      stall = (i % 3 == 2);
      flush = (i == 25);
      if (i % 2 == 0) drive_line(8'(8'hF1 + 8'(3 * i)), 32'hD000_0000 + 32'(16 * i));
      else line_valid = 1'b0;
    end
    step(); line_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (12) step();
    @(negedge clk);
    chk("t7_drained", 32'(occ), 32'd0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
